sort_stream: RTL

- Parametrised successor to the team's 3-input combinational sorter.
- Accepts a frame of DEPTH unsigned WIDTH-bit words over a valid/ready stream and stores them in a register array.
- Sorts the frame in place with odd-even transposition, one compare-exchange phase per clock.
- Streams the sorted frame out over a second valid/ready interface. Used wherever a ranked list larger than three entries is needed.

---
 rtl/sort_stream.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sort_stream.sv
`default_nettype none
// ============================================================================
// Module   : sort_stream
// Brief    : Frame sorter. Loads DEPTH unsigned WIDTH-bit words over a
//            valid/ready stream, sorts them in place by odd-even
//            transposition (one compare-exchange phase per clock), then
//            streams the ranked frame out over a second valid/ready port.
// Options  : SORT_STREAM_INDEX_EN - carry each word's arrival position as a
//            tag and present it on out_index.
// Revision : 1.0 - initial release
// ============================================================================
module sort_stream #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             descend,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
`ifdef SORT_STREAM_INDEX_EN
    output logic [CW-1:0]    out_index,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_LAST_IDX = CW'(DEPTH - 1);
    // Phases 0..DEPTH-1 exchange; phase DEPTH is the hand-over cycle.
    localparam logic [CW:0]   c_PH_END   = (CW + 1)'(DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_wr_cnt;
    logic [CW-1:0]      r_rd_cnt;
    logic [CW:0]        r_phase;
    logic               r_desc;
    logic [WIDTH-1:0]   r_mem     [DEPTH];
    logic [WIDTH-1:0]   w_mem_nxt [DEPTH];
    logic [DEPTH-1:0]   w_swap;
`ifdef SORT_STREAM_INDEX_EN
    logic [CW-1:0]      r_tag     [DEPTH];
    logic [CW-1:0]      w_tag_nxt [DEPTH];
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and output decode; flush overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
`ifdef SORT_STREAM_INDEX_EN
        out_index   = '0;
`endif
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_wr_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_SORT;
                end
            end
            S_SORT: begin
                busy = 1'b1;
                if (r_phase == c_PH_END) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_mem[r_rd_cnt];
                out_last  = (r_rd_cnt == c_LAST_IDX);
`ifdef SORT_STREAM_INDEX_EN
                out_index = r_tag[r_rd_cnt];
`endif
                if (out_ready && (r_rd_cnt == c_LAST_IDX)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
        if (flush) begin
            w_state_nxt = S_LOAD;
        end
    end

    // One odd-even transposition phase: even phases pair (0,1),(2,3)..,
    // odd phases pair (1,2),(3,4)..; equal words never swap (stable).
    always_comb begin
        w_swap = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_swap[i] = (i[0] == r_phase[0]) &&
                        (r_desc ? (r_mem[i] < r_mem[i+1])
                                : (r_mem[i] > r_mem[i+1]));
        end
        w_mem_nxt = r_mem;
`ifdef SORT_STREAM_INDEX_EN
        w_tag_nxt = r_tag;
`endif
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_swap[i]) begin
                w_mem_nxt[i]   = r_mem[i+1];
                w_mem_nxt[i+1] = r_mem[i];
`ifdef SORT_STREAM_INDEX_EN
                w_tag_nxt[i]   = r_tag[i+1];
                w_tag_nxt[i+1] = r_tag[i];
`endif
            end
        end
    end

    // Datapath: frame capture, in-place sorting and drain read pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_phase  <= '0;
            r_desc   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
`ifdef SORT_STREAM_INDEX_EN
                r_tag[i] <= '0;
`endif
            end
        end else if (flush) begin
            // Abort keeps the array but rewinds every pointer.
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_phase  <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        r_mem[r_wr_cnt] <= in_data;
`ifdef SORT_STREAM_INDEX_EN
                        r_tag[r_wr_cnt] <= r_wr_cnt;
`endif
                        if (r_wr_cnt == '0) begin
                            r_desc <= descend;
                        end
                        if (r_wr_cnt == c_LAST_IDX) begin
                            r_wr_cnt <= '0;
                            r_phase  <= '0;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (r_phase != c_PH_END) begin
                        r_mem   <= w_mem_nxt;
`ifdef SORT_STREAM_INDEX_EN
                        r_tag   <= w_tag_nxt;
`endif
                        r_phase <= r_phase + 1'b1;
                    end else begin
                        r_phase  <= '0;
                        r_rd_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_cnt == c_LAST_IDX) begin
                            r_rd_cnt <= '0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_wr_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
